// File: rtl/usb_bit_stuffer.sv
// usb_bit_stuffer: USB TX bit stuffing (a 0 after STUFF_LEN consecutive 1s) with upstream stall.
// Define USB_NRZI_EN to fold NRZI line encoding into the output register.
module usb_bit_stuffer #(
    parameter int STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_stall,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last,
    output logic [3:0] stuff_cnt
);
    localparam logic [0:0] PASS  = 1'b0;
    localparam logic [0:0] STUFF = 1'b1;
    localparam logic [3:0] LEN   = 4'(STUFF_LEN);
    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d, last_q, last_d, pend_q, pend_d, bit_d;
    logic       accept, hit;
    always_comb begin
        accept  = in_valid && state_q == PASS;
        hit     = accept && in_bit && (cnt_q + 4'd1 == LEN);
        state_d = hit ? STUFF : PASS;
        // remembers that the bit which triggered stuffing was the packet's last
        pend_d  = hit && in_last;
        valid_d = accept || state_q == STUFF;
        bit_d   = accept && in_bit;
        last_d  = state_q == STUFF ? pend_q : accept && in_last && !hit;
        cnt_d   = state_q == STUFF ? 4'd0 :
                  !accept          ? cnt_q :
                  !in_bit          ? 4'd0 :
                  hit              ? LEN :
                  in_last          ? 4'd0 : cnt_q + 4'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PASS;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end
`ifdef USB_NRZI_EN
    logic lvl_q, lvl_d, lvl_base;
    always_comb begin
        // line idles at J (1) once a packet has finished
        lvl_base = last_q ? 1'b1 : lvl_q;
        lvl_d    = valid_d && !bit_d ? ~lvl_base : lvl_base;
    end
    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b1;
        else     lvl_q <= lvl_d;
    end
    assign out_bit = lvl_q;
`else
    logic bit_q;
    always_ff @(posedge clk) begin
        if (rst) bit_q <= 1'b0;
        else     bit_q <= bit_d;
    end
    assign out_bit = bit_q;
`endif
    assign in_stall  = state_q == STUFF;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign stuff_cnt = cnt_q;
endmodule

// File: tb/tb_usb_bit_stuffer.sv
// tb_usb_bit_stuffer: scoreboard bench; a run-length reference model predicts the stuffed stream.
module tb_usb_bit_stuffer;
    localparam int N = 6;
`ifdef USB_NRZI_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif
    typedef struct packed {
        logic       b;
        logic       l;
        logic [3:0] c;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_stall, out_bit, out_valid, out_last;
    logic [3:0] stuff_cnt;
    exp_t       exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         n_out = 0;
    int         n_stall = 0;
    int         run = 0;
    logic       ml = 1'b1;
    usb_bit_stuffer #(.STUFF_LEN(N)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_stall(in_stall), .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
        .stuff_cnt(stuff_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        else n_pass++;
    endtask
    // monitor: pops one expectation for every out_valid cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ml = 1'b1;
        end else if (out_valid) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
`ifdef USB_NRZI_EN
                ml = e.b ? ml : ~ml;
                chk("out_bit_nrzi", int'(out_bit), int'(ml));
`else
                chk("out_bit", int'(out_bit), int'(e.b));
`endif
                chk("out_last", int'(out_last), int'(e.l));
                chk("stuff_cnt", int'(stuff_cnt), int'(e.c));
                if (e.l) ml = 1'b1;
            end
        end else begin
`ifdef USB_NRZI_EN
            chk("idle_out_bit", int'(out_bit), int'(ml));
`else
            chk("idle_out_bit", int'(out_bit), 0);
`endif
        end
    end
    // reference model: count the run of 1s, a full run earns an inserted 0
    task automatic send(input logic b, input logic l);
        bit hit;
        chk("stall_before_accept", int'(in_stall), 0);
        in_bit = b; in_valid = 1'b1; in_last = l;
        run = b ? run + 1 : 0;
        hit = (run == N);
        if (hit) begin
            exp_q.push_back('{b: 1'b1, l: 1'b0, c: 4'(N)});
            exp_q.push_back('{b: 1'b0, l: l, c: 4'd0});
            run = 0;
        end else begin
            if (l) run = 0;
            exp_q.push_back('{b: b, l: l, c: 4'(run)});
        end
        @(posedge clk); #1;
        if (hit) begin
            chk("stall_after_run", int'(in_stall), 1);
            n_stall++;
            @(posedge clk); #1;
        end
    endtask
    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("stall_in_gap", int'(in_stall), 0);
        end
    endtask
    initial begin
        int o0, s0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_stall", int'(in_stall), 0);
        chk("rst_stuff_cnt", int'(stuff_cnt), 0);
        chk("rst_out_bit", int'(out_bit), int'(IDLE));
        // seven 1s then 0
        s0 = n_stall;
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        idle(3);
        chk("t2_stall_cycles", n_stall - s0, 1);
        // packet ending on the 6th 1
        for (int i = 0; i < 6; i++) send(1'b1, i == 5);
        idle(1);
        chk("t3_cnt_after_last", int'(stuff_cnt), 0);
        idle(2);
        // twelve 1s back-to-back
        o0 = n_out; s0 = n_stall;
        for (int i = 0; i < 12; i++) send(1'b1, i == 11);
        idle(3);
        chk("t4_out_cycles", n_out - o0, 14);
        chk("t4_stall_cycles", n_stall - s0, 2);
        // five 1s, 3-cycle gap, one more 1
        o0 = n_out;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        idle(3);
        chk("t5_cnt_held", int'(stuff_cnt), 5);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        idle(3);
        chk("t5_out_cycles", n_out - o0, 8);
        // 0,0,1,0 (NRZI line 0,1,1,0)
        send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
        idle(3);
        // reset during the stall cycle
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        in_bit = 1'b1; in_valid = 1'b1; in_last = 1'b0;
        @(posedge clk); #1;
        chk("t6_stall", int'(in_stall), 1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; run = 0;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_out_bit", int'(out_bit), int'(IDLE));
        chk("t6_rst_cnt", int'(stuff_cnt), 0);
        chk("t6_rst_stall", int'(in_stall), 0);
        @(posedge clk); #1;
        chk("t6_no_stuffed_bit", int'(out_valid), 0);
        // random traffic biased towards long runs of 1s
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            send(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 19) == 0));
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
